// File: rtl/mem_stage.sv
// MEM pipeline stage: issues aligned loads/stores over a req/ack data-memory port
// and produces the writeback value. Misaligned or illegal accesses raise mem_exc.
module mem_stage #(
    parameter int XLEN         = 32,
    parameter int WB_SEL_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_mem,
    input  logic [XLEN-1:0]         pc_mem,
    input  logic [XLEN-1:0]         instr_mem,
    input  logic [XLEN-1:0]         alu_mem,
    input  logic [XLEN-1:0]         rs2_mem,
    input  logic                    mem_rd,
    input  logic                    mem_wr,
    input  logic [2:0]              funct3,
    input  logic [WB_SEL_WIDTH-1:0] wb_sel,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [XLEN-1:0]         dmem_addr,
    output logic [XLEN-1:0]         dmem_wdata,
    output logic [XLEN/8-1:0]       dmem_be,
    input  logic [XLEN-1:0]         dmem_rdata,
    input  logic                    dmem_ack,
    output logic                    stall_out,
    output logic                    valid_wb,
    output logic                    mem_exc,
    output logic [XLEN-1:0]         mem_wb,
    output logic [XLEN-1:0]         instr_wb
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam logic [WB_SEL_WIDTH-1:0] WB_PC4 = WB_SEL_WIDTH'(0);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;

    logic [OB-1:0]   offset;
    logic            is_access, size_ok, aligned, legal_acc, bad_acc;
    logic [XLEN-1:0] wb_value;

    logic [2:0]      held_f3;
    logic [OB-1:0]   held_off;
    logic [XLEN-1:0] held_instr, held_alu;
    logic            held_load;

    function automatic logic [NB-1:0] byte_en(input logic [1:0] sz, input logic [OB-1:0] off);
        logic [NB-1:0] m;
        case (sz)
            2'd0:    m = NB'(1);
            2'd1:    m = NB'(3);
            2'd2:    m = NB'(15);
            default: m = NB'(255);
        endcase
        return m << off;
    endfunction

    function automatic logic [XLEN-1:0] rep_data(input logic [1:0] sz, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (sz)
            2'd0:    r = {NB{d[7:0]}};
            2'd1:    r = {(NB/2){d[15:0]}};
            2'd2:    r = {(NB/4){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [OB-1:0] off,
                                                 input logic [XLEN-1:0] d);
        logic [XLEN-1:0] s, r;
        s = d >> {off, 3'b000};
        case (f3[1:0])
            2'd0:    r = f3[2] ? XLEN'(s[7:0])  : XLEN'($signed(s[7:0]));
            2'd1:    r = f3[2] ? XLEN'(s[15:0]) : XLEN'($signed(s[15:0]));
            2'd2:    r = f3[2] ? XLEN'(s[31:0]) : XLEN'($signed(s[31:0]));
            default: r = s;
        endcase
        return r;
    endfunction

    // Access classification: 111 never legal, 011/110 need a 64-bit datapath,
    // stores have no unsigned variants.
    always_comb begin
        offset    = alu_mem[OB-1:0];
        is_access = mem_rd | mem_wr;
        size_ok   = (funct3 != 3'b111) && !(mem_rd && mem_wr) && !(mem_wr && funct3[2]) &&
                    ((XLEN == 64) || ((funct3 != 3'b011) && (funct3 != 3'b110)));
        case (funct3[1:0])
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~alu_mem[0];
            2'd2:    aligned = (alu_mem[1:0] == 2'b00);
            default: aligned = (alu_mem[2:0] == 3'b000);
        endcase
        legal_acc = is_access & size_ok & aligned;
        bad_acc   = is_access & ~(size_ok & aligned);
        // ALU and MEM codes both return alu_mem when no memory access is made.
        wb_value  = (wb_sel == WB_PC4) ? pc_mem + XLEN'(4) : alu_mem;
    end

    always_comb begin
        state_nx  = state;
        stall_out = 1'b0;
        case (state)
            IDLE: begin
                if (valid_mem && legal_acc) begin
                    state_nx  = BUSY;
                    stall_out = rst_n;
                end
            end
            BUSY: begin
                if (dmem_ack) state_nx = IDLE;
                else          stall_out = rst_n;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            valid_wb   <= 1'b0;
            mem_exc    <= 1'b0;
            mem_wb     <= '0;
            instr_wb   <= '0;
            held_f3    <= '0;
            held_off   <= '0;
            held_instr <= '0;
            held_alu   <= '0;
            held_load  <= 1'b0;
        end else begin
            valid_wb <= 1'b0;
            mem_exc  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_mem && legal_acc) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_wr;
                        dmem_addr  <= {alu_mem[XLEN-1:OB], {OB{1'b0}}};
                        dmem_wdata <= rep_data(funct3[1:0], rs2_mem);
                        dmem_be    <= byte_en(funct3[1:0], offset);
                        held_f3    <= funct3;
                        held_off   <= offset;
                        held_instr <= instr_mem;
                        held_alu   <= alu_mem;
                        held_load  <= mem_rd;
                    end else if (valid_mem) begin
                        valid_wb <= 1'b1;
                        mem_exc  <= bad_acc;
                        instr_wb <= instr_mem;
                        mem_wb   <= bad_acc ? alu_mem : wb_value;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        valid_wb <= 1'b1;
                        instr_wb <= held_instr;
                        mem_wb   <= held_load ? load_ext(held_f3, held_off, dmem_rdata) : held_alu;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: 32- and 64-bit instances, directed scenarios plus random
// transactions checked against a byte-level reference model.
module tb_mem_stage;
    localparam logic [1:0] WB_PC4 = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel64 = 1'b0, valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, ack = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  wb_sel = '0;
    logic [63:0] pc = '0, instr = '0, alu = '0, rs2 = '0, rdata = '0;

    logic        r32_req, r32_we, r32_stall, r32_vwb, r32_exc;
    logic [31:0] r32_addr, r32_wdata, r32_wb, r32_iwb;
    logic [3:0]  r32_be;
    logic        r64_req, r64_we, r64_stall, r64_vwb, r64_exc;
    logic [63:0] r64_addr, r64_wdata, r64_wb, r64_iwb;
    logic [7:0]  r64_be;

    logic        o_req, o_we, o_stall, o_vwb, o_exc;
    logic [63:0] o_addr, o_wdata, o_wb, o_iwb;
    logic [7:0]  o_be;

    logic        ob_stall0, ob_req, ob_we, ob_stable, ob_stall_ack, ob_vwb, ob_exc, ob_vwb_next;
    logic [63:0] ob_addr, ob_wdata, ob_wb, ob_iwb;
    logic [7:0]  ob_be;
    int          ob_stalls;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32), .WB_SEL_WIDTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .valid_mem(valid & ~sel64),
        .pc_mem(pc[31:0]), .instr_mem(instr[31:0]), .alu_mem(alu[31:0]), .rs2_mem(rs2[31:0]),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .wb_sel(wb_sel),
        .dmem_req(r32_req), .dmem_we(r32_we), .dmem_addr(r32_addr), .dmem_wdata(r32_wdata),
        .dmem_be(r32_be), .dmem_rdata(rdata[31:0]), .dmem_ack(ack & ~sel64),
        .stall_out(r32_stall), .valid_wb(r32_vwb), .mem_exc(r32_exc),
        .mem_wb(r32_wb), .instr_wb(r32_iwb)
    );

    mem_stage #(.XLEN(64), .WB_SEL_WIDTH(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .valid_mem(valid & sel64),
        .pc_mem(pc), .instr_mem(instr), .alu_mem(alu), .rs2_mem(rs2),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .wb_sel(wb_sel),
        .dmem_req(r64_req), .dmem_we(r64_we), .dmem_addr(r64_addr), .dmem_wdata(r64_wdata),
        .dmem_be(r64_be), .dmem_rdata(rdata), .dmem_ack(ack & sel64),
        .stall_out(r64_stall), .valid_wb(r64_vwb), .mem_exc(r64_exc),
        .mem_wb(r64_wb), .instr_wb(r64_iwb)
    );

    always_comb begin
        o_req   = sel64 ? r64_req   : r32_req;
        o_we    = sel64 ? r64_we    : r32_we;
        o_stall = sel64 ? r64_stall : r32_stall;
        o_vwb   = sel64 ? r64_vwb   : r32_vwb;
        o_exc   = sel64 ? r64_exc   : r32_exc;
        o_addr  = sel64 ? r64_addr  : {32'b0, r32_addr};
        o_wdata = sel64 ? r64_wdata : {32'b0, r32_wdata};
        o_wb    = sel64 ? r64_wb    : {32'b0, r32_wb};
        o_iwb   = sel64 ? r64_iwb   : {32'b0, r32_iwb};
        o_be    = sel64 ? r64_be    : {4'b0, r32_be};
    end

    // Reference: what a memory access should look like, from size/offset arithmetic.
    function automatic void model(input int xl, input logic [2:0] f3, input logic rd, input logic wr,
                                  input logic [63:0] a, input logic [63:0] d, input logic [63:0] rdat,
                                  output logic acc, output logic exc, output logic [63:0] addr,
                                  output logic [63:0] be, output logic [63:0] wdata, output logic [63:0] ld);
        int nb, sz, off;
        logic legal;
        logic [63:0] m, v, low;
        nb    = xl / 8;
        sz    = 1 << f3[1:0];
        off   = int'(a % 64'(nb));
        m     = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        legal = (f3 != 3'd7) && !(rd && wr) && !(wr && f3 >= 3'd4) &&
                (xl == 64 || (f3 != 3'd3 && f3 != 3'd6));
        acc   = (rd || wr) && legal && (off % sz == 0);
        exc   = (rd || wr) && !acc;
        addr  = (a & m) - 64'(off);
        be    = ((64'd1 << sz) - 64'd1) << off;
        wdata = '0;
        for (int i = 0; i < nb; i++) wdata |= ((d >> (8 * (i % sz))) & 64'hFF) << (8 * i);
        v = (rdat & m) >> (8 * off);
        if (sz < 8) begin
            low = (64'd1 << (8 * sz)) - 64'd1;
            v = v & low;
            if (!f3[2] && v[8*sz-1]) v = v | ~low;
        end
        ld = v & m;
    endfunction

    // Drives one instruction, answers a granted access after dly wait cycles, records outputs.
    task automatic run_op(input logic [2:0] f3, input logic rd, input logic wr, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] rdat, input logic [1:0] ws, input int dly);
        pc = {$urandom, $urandom}; instr = {$urandom, $urandom};
        funct3 = f3; mem_rd = rd; mem_wr = wr; alu = a; rs2 = d; wb_sel = ws;
        valid = 1'b1;
        #1;
        ob_stall0 = o_stall;
        ob_stalls = int'(o_stall);
        @(posedge clk); #1;
        valid = 1'b0;
        ob_req = o_req; ob_we = o_we; ob_addr = o_addr; ob_be = o_be; ob_wdata = o_wdata;
        ob_stable = 1'b1; ob_stall_ack = 1'b0;
        if (o_req) begin
            for (int k = 0; k <= dly; k++) begin
                if (o_req !== 1'b1 || o_we !== ob_we || o_addr !== ob_addr || o_be !== ob_be ||
                    o_wdata !== ob_wdata) ob_stable = 1'b0;
                if (k == dly) begin
                    ack = 1'b1; rdata = rdat;
                    #1;
                    ob_stall_ack = o_stall;
                end else begin
                    ob_stalls += int'(o_stall);
                end
                @(posedge clk); #1;
                ack = 1'b0; rdata = {$urandom, $urandom};
            end
        end
        ob_vwb = o_vwb; ob_exc = o_exc; ob_wb = o_wb; ob_iwb = o_iwb;
        @(posedge clk); #1;
        ob_vwb_next = o_vwb;
    endtask

    task automatic test_reset();
        sel64 = 1'b0; valid = 1'b1; mem_rd = 1'b1; funct3 = 3'd2; alu = 64'h100;
        #3;
        n_cmp++;
        if ({r32_req, r32_we, r32_stall, r32_vwb, r32_exc, r64_req, r64_we, r64_stall, r64_vwb, r64_exc} !== 10'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0",
                {r32_req, r32_we, r32_stall, r32_vwb, r32_exc, r64_req, r64_we, r64_stall, r64_vwb, r64_exc});
        end
        n_cmp++;
        if ({r32_be, r64_be} !== 12'h0 || r32_addr !== 32'h0 || r64_addr !== 64'h0 ||
            r32_wdata !== 32'h0 || r64_wdata !== 64'h0) begin
            n_err++; $display("FAIL reset_dmem: got be %h/%h addr %h/%h want 0", r32_be, r64_be, r32_addr, r64_addr);
        end
        n_cmp++;
        if (r32_wb !== 32'h0 || r32_iwb !== 32'h0 || r64_wb !== 64'h0 || r64_iwb !== 64'h0) begin
            n_err++; $display("FAIL reset_wb: got %h %h %h %h want 0", r32_wb, r32_iwb, r64_wb, r64_iwb);
        end
        valid = 1'b0; mem_rd = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_op();
        sel64 = 1'b0;
        run_op(3'd0, 1'b0, 1'b0, 64'h1234, 64'h0, 64'h0, WB_ALU, 0);
        n_cmp++;
        if (ob_stall0 !== 1'b0 || ob_req !== 1'b0) begin
            n_err++; $display("FAIL alu_nostall: got stall %b req %b want 0 0", ob_stall0, ob_req);
        end
        n_cmp++;
        if ({ob_vwb, ob_exc, ob_vwb_next} !== 3'b100 || ob_wb !== 64'h1234) begin
            n_err++; $display("FAIL alu_wb: got v %b exc %b next %b wb %h want 1 0 0 1234",
                ob_vwb, ob_exc, ob_vwb_next, ob_wb);
        end
        n_cmp++;
        if (ob_iwb !== (instr & 64'hFFFF_FFFF)) begin
            n_err++; $display("FAIL alu_instr: got %h want %h", ob_iwb, instr & 64'hFFFF_FFFF);
        end
        run_op(3'd0, 1'b0, 1'b0, 64'h55, 64'h0, 64'h0, WB_PC4, 0);
        n_cmp++;
        if (ob_wb !== ((pc + 64'd4) & 64'hFFFF_FFFF)) begin
            n_err++; $display("FAIL pc4_wb: got %h want %h", ob_wb, (pc + 64'd4) & 64'hFFFF_FFFF);
        end
    endtask

    task automatic test_load_byte();
        sel64 = 1'b0;
        run_op(3'd0, 1'b1, 1'b0, 64'h1003, 64'h0, 64'h80FF_FFFF, WB_ALU, 2);
        n_cmp++;
        if (ob_be !== 8'h8 || ob_stable !== 1'b1 || ob_addr !== 64'h1000 || ob_we !== 1'b0) begin
            n_err++; $display("FAIL lb_dmem: got be %h stable %b addr %h we %b want 8 1 1000 0",
                ob_be, ob_stable, ob_addr, ob_we);
        end
        n_cmp++;
        if (ob_stalls != 3 || ob_stall_ack !== 1'b0) begin
            n_err++; $display("FAIL lb_stall: got %0d cycles, ack-cycle %b want 3 0", ob_stalls, ob_stall_ack);
        end
        n_cmp++;
        if (ob_vwb !== 1'b1 || ob_wb !== 64'hFFFF_FF80) begin
            n_err++; $display("FAIL lb_wb: got v %b wb %h want 1 ffffff80", ob_vwb, ob_wb);
        end
        run_op(3'd4, 1'b1, 1'b0, 64'h1003, 64'h0, 64'h80FF_FFFF, WB_ALU, 2);
        n_cmp++;
        if (ob_wb !== 64'h80 || ob_be !== 8'h8) begin
            n_err++; $display("FAIL lbu_wb: got wb %h be %h want 80 8", ob_wb, ob_be);
        end
    endtask

    task automatic test_store_half();
        sel64 = 1'b0;
        run_op(3'd1, 1'b0, 1'b1, 64'h2002, 64'hABCD_1234, 64'h0, WB_ALU, 0);
        n_cmp++;
        if (ob_we !== 1'b1 || ob_be !== 8'hC || ob_wdata !== 64'h1234_1234 || ob_addr !== 64'h2000) begin
            n_err++; $display("FAIL sh_dmem: got we %b be %h wdata %h addr %h want 1 c 12341234 2000",
                ob_we, ob_be, ob_wdata, ob_addr);
        end
        n_cmp++;
        if (ob_vwb !== 1'b1 || ob_exc !== 1'b0 || ob_wb !== 64'h2002 || ob_stalls != 1) begin
            n_err++; $display("FAIL sh_wb: got v %b exc %b wb %h stalls %0d want 1 0 2002 1",
                ob_vwb, ob_exc, ob_wb, ob_stalls);
        end
    endtask

    task automatic test_exceptions();
        sel64 = 1'b0;
        run_op(3'd2, 1'b1, 1'b0, 64'h3001, 64'h0, 64'h0, WB_PC4, 0);
        n_cmp++;
        if (ob_req !== 1'b0 || ob_stall0 !== 1'b0 || {ob_vwb, ob_exc} !== 2'b11 || ob_wb !== 64'h3001) begin
            n_err++; $display("FAIL lw_misalign: got req %b stall %b v %b exc %b wb %h want 0 0 1 1 3001",
                ob_req, ob_stall0, ob_vwb, ob_exc, ob_wb);
        end
        n_cmp++;
        if (ob_vwb_next !== 1'b0) begin
            n_err++; $display("FAIL exc_pulse: got %b want 0", ob_vwb_next);
        end
        run_op(3'd2, 1'b1, 1'b1, 64'h4000, 64'h0, 64'h0, WB_ALU, 0);
        n_cmp++;
        if (ob_req !== 1'b0 || ob_exc !== 1'b1 || ob_wb !== 64'h4000) begin
            n_err++; $display("FAIL rd_wr_both: got req %b exc %b wb %h want 0 1 4000", ob_req, ob_exc, ob_wb);
        end
        run_op(3'd4, 1'b0, 1'b1, 64'h4100, 64'h0, 64'h0, WB_ALU, 0);
        n_cmp++;
        if (ob_req !== 1'b0 || ob_exc !== 1'b1) begin
            n_err++; $display("FAIL store_unsigned: got req %b exc %b want 0 1", ob_req, ob_exc);
        end
    endtask

    task automatic test_xlen();
        sel64 = 1'b0;
        run_op(3'd3, 1'b1, 1'b0, 64'h8, 64'h0, 64'h0, WB_ALU, 0);
        n_cmp++;
        if (ob_req !== 1'b0 || ob_exc !== 1'b1) begin
            n_err++; $display("FAIL ld_on_32: got req %b exc %b want 0 1", ob_req, ob_exc);
        end
        sel64 = 1'b1;
        run_op(3'd3, 1'b1, 1'b0, 64'h8, 64'h0, 64'hFEDC_BA98_7654_3210, WB_ALU, 1);
        n_cmp++;
        if (ob_be !== 8'hFF || ob_addr !== 64'h8 || ob_wb !== 64'hFEDC_BA98_7654_3210 || ob_exc !== 1'b0) begin
            n_err++; $display("FAIL ld_on_64: got be %h addr %h wb %h exc %b want ff 8 fedcba9876543210 0",
                ob_be, ob_addr, ob_wb, ob_exc);
        end
        run_op(3'd6, 1'b1, 1'b0, 64'h14, 64'h0, 64'h8000_0001_0000_0000, WB_ALU, 0);
        n_cmp++;
        if (ob_be !== 8'hF0 || ob_wb !== 64'h8000_0001) begin
            n_err++; $display("FAIL lwu_on_64: got be %h wb %h want f0 80000001", ob_be, ob_wb);
        end
        sel64 = 1'b0;
    endtask

    task automatic test_idle_hold();
        logic bad;
        sel64 = 1'b0;
        run_op(3'd0, 1'b0, 1'b0, 64'hBEEF, 64'h0, 64'h0, WB_ALU, 0);
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ack = (k == 1);
            @(posedge clk); #1;
            if (o_vwb !== 1'b0 || o_req !== 1'b0 || o_wb !== 64'hBEEF) bad = 1'b1;
        end
        ack = 1'b0;
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++; $display("FAIL idle_hold: got v %b req %b wb %h want 0 0 beef", o_vwb, o_req, o_wb);
        end
    endtask

    task automatic test_reset_busy();
        logic bad;
        sel64 = 1'b0; funct3 = 3'd2; mem_rd = 1'b1; mem_wr = 1'b0; alu = 64'h40; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        n_cmp++;
        if (r32_req !== 1'b1) begin
            n_err++; $display("FAIL rstbusy_enter: got req %b want 1", r32_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (r32_req !== 1'b0 || r32_stall !== 1'b0) begin
            n_err++; $display("FAIL rstbusy_drop: got req %b stall %b want 0 0", r32_req, r32_stall);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        ack = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            ack = 1'b0;
            if (r32_vwb !== 1'b0 || r32_req !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++; $display("FAIL rstbusy_novalid: got v %b req %b want 0 0", r32_vwb, r32_req);
        end
        run_op(3'd2, 1'b1, 1'b0, 64'h44, 64'h0, 64'h1357_9BDF, WB_ALU, 1);
        n_cmp++;
        if (ob_vwb !== 1'b1 || ob_wb !== 64'h1357_9BDF || ob_be !== 8'hF) begin
            n_err++; $display("FAIL rstbusy_next: got v %b wb %h be %h want 1 13579bdf f", ob_vwb, ob_wb, ob_be);
        end
    endtask

    task automatic test_random();
        logic acc, exc, rd, wr;
        logic [63:0] a, d, rdat, e_addr, e_be, e_wd, e_ld, e_wb, m;
        logic [2:0] f3;
        logic [1:0] ws;
        int xl, dly, sel;
        for (int n = 0; n < 200; n++) begin
            sel64 = 1'($urandom_range(0, 1));
            xl = sel64 ? 64 : 32;
            m = sel64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
            f3 = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            rd = (sel >= 2 && sel <= 5) || sel == 9;
            wr = (sel >= 6);
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << (1 << f3[1:0])) - 64'd1);
            d = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            ws = 2'($urandom_range(0, 1));
            dly = $urandom_range(0, 3);
            run_op(f3, rd, wr, a, d, rdat, ws, dly);
            model(xl, f3, rd, wr, a, d, rdat, acc, exc, e_addr, e_be, e_wd, e_ld);
            e_wb = acc ? (rd ? e_ld : (a & m)) : (exc ? (a & m) : ((ws == WB_PC4) ? ((pc + 64'd4) & m) : (a & m)));
            n_cmp++;
            if (ob_req !== acc || ob_stall0 !== acc) begin
                n_err++; $display("FAIL rnd_req[%0d]: got req %b stall %b want %b", n, ob_req, ob_stall0, acc);
            end
            if (acc) begin
                n_cmp++;
                if (ob_addr !== e_addr || ob_be !== e_be[7:0] || ob_wdata !== (e_wd & m) || ob_we !== wr) begin
                    n_err++; $display("FAIL rnd_dmem[%0d]: got %h %h %h %b want %h %h %h %b", n,
                        ob_addr, ob_be, ob_wdata, ob_we, e_addr, e_be[7:0], e_wd & m, wr);
                end
                n_cmp++;
                if (ob_stable !== 1'b1 || ob_stalls != dly + 1 || ob_stall_ack !== 1'b0) begin
                    n_err++; $display("FAIL rnd_hs[%0d]: got stable %b stalls %0d ackstall %b want 1 %0d 0", n,
                        ob_stable, ob_stalls, ob_stall_ack, dly + 1);
                end
            end
            n_cmp++;
            if ({ob_vwb, ob_exc, ob_vwb_next} !== {1'b1, exc, 1'b0} || ob_wb !== e_wb || ob_iwb !== (instr & m)) begin
                n_err++; $display("FAIL rnd_wb[%0d]: got v %b exc %b nx %b wb %h iwb %h want 1 %b 0 %h %h", n,
                    ob_vwb, ob_exc, ob_vwb_next, ob_wb, ob_iwb, exc, e_wb, instr & m);
            end
        end
        sel64 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_byte();
        test_store_half();
        test_exceptions();
        test_xlen();
        test_idle_hold();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
